// File: rtl/hero_cmd_sched_pkg.sv
// Command codes, FSM state encodings and priority helpers shared by the
// hero command scheduler, the hero controller and the bench.
package hero_cmd_sched_pkg;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_UP     = 3'd1;
    localparam logic [2:0] CMD_LEFT   = 3'd2;
    localparam logic [2:0] CMD_RIGHT  = 3'd3;
    localparam logic [2:0] CMD_DOWN   = 3'd4;
    localparam logic [2:0] CMD_ATTACK = 3'd5;

    localparam int unsigned NUM_BTN = 5;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // Button vector bit order: [0]=up [1]=left [2]=right [3]=down [4]=center.
    function automatic logic [2:0] prio_code(input logic [NUM_BTN-1:0] v);
        if (v[0])      return CMD_UP;
        else if (v[1]) return CMD_LEFT;
        else if (v[2]) return CMD_RIGHT;
        else if (v[3]) return CMD_DOWN;
        else if (v[4]) return CMD_ATTACK;
        else           return CMD_NONE;
    endfunction

    function automatic logic [NUM_BTN-1:0] code_onehot(input logic [2:0] c);
        case (c)
            CMD_UP:     return 5'b00001;
            CMD_LEFT:   return 5'b00010;
            CMD_RIGHT:  return 5'b00100;
            CMD_DOWN:   return 5'b01000;
            CMD_ATTACK: return 5'b10000;
            default:    return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/hero_cmd_sched_btn_debounce.sv
// One button: 2-FF synchronizer plus consecutive-cycle debounce counter.
// level is the debounced state; rise pulses for one cycle when it goes high.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any agreement with the stable level restarts the qualification window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                rise  <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hero_cmd_sched.sv
// Debounced, priority-arbitrated, rate-limited hero command pulse generator
// with a single-entry newest-wins buffer for presses made during hold-off.
module hero_cmd_sched
    import hero_cmd_sched_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned COOLDOWN_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic btn_up,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_center,
    output logic cmd_up,
    output logic cmd_left,
    output logic cmd_right,
    output logic cmd_down,
    output logic cmd_center,
    output logic busy
);

    localparam int unsigned CCW = $clog2(COOLDOWN_CYCLES + 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] cmd;
    logic [2:0]         held_code;
    logic [2:0]         edge_code;
    logic [2:0]         pend_code;
    logic               pend_valid;
    logic [CCW-1:0]     cool_cnt;
    state_t             state;

    assign raw = {btn_center, btn_down, btn_right, btn_left, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    assign held_code = prio_code(level);
    assign edge_code = prio_code(rise);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_READY;
            cool_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_code  <= CMD_NONE;
            cmd        <= '0;
            busy       <= 1'b0;
        end else begin
            cmd <= '0;
            case (state)
                ST_READY: begin
                    if (enable && pend_valid) begin
                        cmd   <= code_onehot(pend_code);
                        busy  <= 1'b1;
                        state <= ST_ISSUE;
                    end else if (enable && (|level)) begin
                        cmd   <= code_onehot(held_code);
                        busy  <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cool_cnt <= CCW'(COOLDOWN_CYCLES);
                    state    <= ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    if (cool_cnt == CCW'(1)) begin
                        busy  <= 1'b0;
                        state <= ST_READY;
                    end else begin
                        cool_cnt <= cool_cnt - CCW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_READY;
                end
            endcase

            // Pending buffer: enable low wins, then newest edge, then consumption.
            if (!enable) begin
                pend_valid <= 1'b0;
            end else if (state != ST_READY && (|rise)) begin
                pend_valid <= 1'b1;
                pend_code  <= edge_code;
            end else if (state == ST_READY && pend_valid) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign cmd_up     = cmd[0];
    assign cmd_left   = cmd[1];
    assign cmd_right  = cmd[2];
    assign cmd_down   = cmd[3];
    assign cmd_center = cmd[4];

endmodule

// File: tb/tb_hero_cmd_sched.sv
// Directed bench for hero_cmd_sched: expected pulses (code, cycle) are queued
// as stimulus is driven and matched against every observed pulse.
module tb_hero_cmd_sched;
    import hero_cmd_sched_pkg::*;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic btn_up = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_center = 1'b0;
    logic cmd_up, cmd_left, cmd_right, cmd_down, cmd_center, busy;
    logic [4:0] cmds;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    hero_cmd_sched #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .btn_up    (btn_up),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_down  (btn_down),
        .btn_center(btn_center),
        .cmd_up    (cmd_up),
        .cmd_left  (cmd_left),
        .cmd_right (cmd_right),
        .cmd_down  (cmd_down),
        .cmd_center(cmd_center),
        .busy      (busy)
    );

    assign cmds = {cmd_center, cmd_down, cmd_right, cmd_left, cmd_up};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] decode(input logic [4:0] v);
        case (v)
            5'b00001: return CMD_UP;
            5'b00010: return CMD_LEFT;
            5'b00100: return CMD_RIGHT;
            5'b01000: return CMD_DOWN;
            5'b10000: return CMD_ATTACK;
            default:  return CMD_NONE;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(input logic [2:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    // Scoreboard side: every observed pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (cmds !== 5'b0) begin
            exp_t e;
            chk("onehot", int'($countones(cmds)), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'(decode(cmds)), int'(CMD_NONE));
            end else begin
                e = exp_q.pop_front();
                chk("pulse_code", int'(decode(cmds)), int'(e.code));
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c;
        int nbusy;

        // Reset state
        tick();
        tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_cmds", int'(cmds), 0);
        rst = 1'b0;
        wait_to(cyc + 3);

        // Bounce: short toggles never qualify, final hold yields one cmd_up
        for (int i = 0; i < 10; i++) begin
            btn_up = (i % 2 == 0);
            tick();
            tick();
        end
        c = cyc;
        btn_up = 1'b1;
        push(CMD_UP, c + 7);
        wait_to(c + 7);
        chk("bounce_busy_rise", int'(busy), 1);
        btn_up = 1'b0;
        wait_to(c + 22);

        // Hold-to-repeat: cmd_right every 10 cycles, busy 9 of each 10
        c = cyc;
        btn_right = 1'b1;
        for (int k = 0; k < 7; k++) push(CMD_RIGHT, c + 7 + 10 * k);
        wait_to(c + 16);
        nbusy = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy === 1'b1) nbusy++;
        end
        chk("hold_busy_count", nbusy, 9);
        wait_to(c + 66);
        btn_right = 1'b0;
        wait_to(c + 80);
        chk("hold_idle_busy", int'(busy), 0);

        // Simultaneous left+down: left wins, down follows once left released
        c = cyc;
        btn_left = 1'b1;
        btn_down = 1'b1;
        push(CMD_LEFT, c + 7);
        push(CMD_DOWN, c + 17);
        wait_to(c + 8);
        btn_left = 1'b0;
        wait_to(c + 18);
        btn_down = 1'b0;
        wait_to(c + 30);

        // Buffer: center then down tapped in cooldown, newest (down) issued
        c = cyc;
        btn_up = 1'b1;
        push(CMD_UP, c + 7);
        push(CMD_DOWN, c + 17);
        wait_to(c + 3);
        btn_center = 1'b1;
        wait_to(c + 5);
        btn_down = 1'b1;
        wait_to(c + 6);
        btn_up = 1'b0;
        wait_to(c + 9);
        btn_center = 1'b0;
        wait_to(c + 11);
        btn_down = 1'b0;
        wait_to(c + 16);
        chk("buffer_busy_fall", int'(busy), 0);
        wait_to(c + 17);
        chk("buffer_busy_reissue", int'(busy), 1);
        wait_to(c + 32);

        // Enable low clears a buffered center; held up issues once re-enabled
        c = cyc;
        btn_up = 1'b1;
        push(CMD_UP, c + 7);
        wait_to(c + 3);
        btn_center = 1'b1;
        wait_to(c + 9);
        btn_center = 1'b0;
        wait_to(c + 12);
        enable = 1'b0;
        wait_to(c + 30);
        chk("enable_low_busy", int'(busy), 0);
        enable = 1'b1;
        push(CMD_UP, c + 31);
        wait_to(c + 32);
        btn_up = 1'b0;
        wait_to(c + 45);

        // Asynchronous reset during cooldown
        c = cyc;
        btn_right = 1'b1;
        push(CMD_RIGHT, c + 7);
        wait_to(c + 10);
        chk("pre_reset_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_cmds", int'(cmds), 0);
        btn_right = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wait_to(cyc + 20);
        chk("post_reset_busy", int'(busy), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hero_cmd_sched.md
# hero_cmd_sched

Turns the five raw board buttons into clean, rate-limited, one-cycle move/attack command pulses for the hero controller. It debounces each button and arbitrates simultaneous presses with a fixed priority. Each command is held off until the hero has finished its previous 60-step move or attack, and one press made during that hold-off is buffered. It sits between the board I/O and the hero controller's up/left/right/down/center inputs.

## Interface
- DEBOUNCE_CYCLES, default 100000: consecutive stable cycles required before a debounced level changes.
- COOLDOWN_CYCLES, default 64: hold-off after each issued command. Must be ≥ 62 so the hero is back in IDLE before the next pulse.
- clk  input  1  system clock; the only clock.
- rst  input  1  reset; asynchronous, active-high.
- enable  input  1  gameplay running. Low suppresses issuing and clears the pending buffer.
- btn_up, btn_left, btn_right, btn_down, btn_center  input  1 each  raw, asynchronous button levels.
- cmd_up, cmd_left, cmd_right, cmd_down, cmd_center  output  1 each  registered one-cycle command pulses. At most one is high in any cycle.
- busy  output  1  high during ISSUE and COOLDOWN.

## Operation
- **Per-button path**
  - 2-FF synchronizer feeds a debounce counter.
  - The stable level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the stable value clears the counter.
  - A rising edge of the stable level is an "edge event".
- **Priority**, highest first: up > left > right > down > center. Command code is 3 bits: NONE=0, UP=1, LEFT=2, RIGHT=3, DOWN=4, ATTACK=5.
- **Pending buffer**: one entry (code plus valid bit).
  - Loaded during ISSUE or COOLDOWN when an edge event occurs.
  - Several edges in the same cycle: the highest-priority one is stored.
  - A later edge overwrites the earlier entry; newest wins.
  - Cleared when the buffer is consumed, or in any cycle with enable low.
- **FSM**
  - READY: if enable is high and pending is valid, issue the pending code. Otherwise, if enable is high and any debounced level is high, issue the highest-priority held button (hold-to-repeat). Issuing means going to ISSUE. Otherwise stay in READY.
  - ISSUE: exactly one cycle; the matching cmd_* is high. Go to COOLDOWN and load the cooldown counter.
  - COOLDOWN: stay for exactly COOLDOWN_CYCLES cycles, then go to READY. Continues regardless of enable.
- **Edge and held button in the same cycle in READY**: the edge's code is issued (it appears in the priority levels), and no buffer entry is created.
- **Reset values**: all cmd_* = 0, busy = 0, state READY, pending invalid, synchronizers, debounced levels and counters = 0.
- **Reset mid-operation**: asynchronous return to the reset values. No pulse is emitted in the cycle following reset release unless a debounced level is already high, which it cannot be.

## Timing
- Raw press held stable → debounced high DEBOUNCE_CYCLES+2 cycles later.
- Debounced high observed in READY → cmd_* high on the next clk edge, width 1 cycle.
- Held button repeat period = COOLDOWN_CYCLES+2 cycles (READY, ISSUE, COOLDOWN×N).
- busy rises with the pulse and falls COOLDOWN_CYCLES+1 cycles later.
- Cooldown counter width is $clog2(COOLDOWN_CYCLES+1); debounce counter width is $clog2(DEBOUNCE_CYCLES+1). Neither counter wraps: both saturate or reload.

## Structure
- A shared package/header holds the command-code localparams (NONE..ATTACK) and the FSM state encodings, so the hero controller and the test bench decode identically.
- Sub-module btn_debounce (synchronizer plus counter; outputs level and rise pulse; parameter DEBOUNCE_CYCLES) is instantiated five times.
- Arbitration, the pending buffer and the FSM stay in hero_cmd_sched.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8.
- Bounce: btn_up toggles every 2 cycles for 20 cycles, then holds high → no pulse during bouncing. A single cmd_up appears 7 cycles after the final rising transition (6 cycles to debounce plus 1 to issue).
- Hold: btn_right held high for 60 cycles after debounce → cmd_right pulses every 10 cycles. busy is high for 9 of each 10 cycles.
- Simultaneous: btn_left and btn_down rise in the same cycle → only cmd_left pulses. cmd_down follows 10 cycles later only if btn_down is still held and btn_left has been released.
- Buffer: cmd_up issued; btn_center tapped, then btn_down tapped (both debounced) inside the cooldown, all buttons released → exactly one cmd_down, in the second cycle after busy falls; no cmd_center.
- Enable: enable low while btn_up is held → no pulses, pending cleared. enable high → cmd_up on the next READY cycle.
- Reset: assert rst during COOLDOWN → busy and cmd_* are 0 immediately, with no clock needed. After release with no buttons pressed, outputs stay 0.
